// File: rtl/hall_pkg.sv
// Shared constants and hall-sequence helpers for the hall speed sensor.
package hall_pkg;

  localparam logic [2:0] ADDR_ID     = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_POS    = 3'd3;
  localparam logic [2:0] ADDR_TMO    = 3'd4;
  localparam logic [2:0] ADDR_CTRL   = 3'd5;

  localparam logic [31:0] HALL_ID = 32'hEA68_0004;

  typedef enum logic [2:0] {
    H_100 = 3'b100,
    H_110 = 3'b110,
    H_010 = 3'b010,
    H_011 = 3'b011,
    H_001 = 3'b001,
    H_101 = 3'b101
  } hall_e;

  function automatic logic hall_legal(input logic [2:0] h);
    return (h != 3'b000) && (h != 3'b111);
  endfunction

  function automatic logic [2:0] hall_next(input logic [2:0] h);
    case (h)
      H_100:   return H_110;
      H_110:   return H_010;
      H_010:   return H_011;
      H_011:   return H_001;
      H_001:   return H_101;
      H_101:   return H_100;
      default: return h;
    endcase
  endfunction

  function automatic logic [2:0] hall_prev(input logic [2:0] h);
    case (h)
      H_100:   return H_101;
      H_110:   return H_100;
      H_010:   return H_110;
      H_011:   return H_010;
      H_001:   return H_011;
      H_101:   return H_001;
      default: return h;
    endcase
  endfunction

  function automatic logic [31:0] be_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/hall_filter.sv
// Two-flop synchroniser plus FILT_LEN-sample debounce on the hall bus.
module hall_filter
  import hall_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] raw_i,
  output logic [2:0] state_o,
  output logic       chg_o
);

  localparam logic [7:0] FL = 8'(FILT_LEN);

  logic [2:0] s1_q, s2_q;
  logic [2:0] cand_q, cand_d;
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d, run;
  logic       chg_d;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    chg_d   = 1'b0;
    run     = (s2_q == cand_q && cnt_q != 8'd0)
            ? cnt_q + 8'd1 : 8'd1;
    if (s2_q == state_q) begin
      cnt_d = 8'd0;
    end else if (run >= FL) begin
      state_d = s2_q;
      cnt_d   = 8'd0;
      chg_d   = 1'b1;
    end else begin
      cand_d = s2_q;
      cnt_d  = run;
    end
  end

  // Strobe and value are combinational so the consumer
  // registers them on the same edge as the accept.
  assign chg_o   = chg_d;
  assign state_o = s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 3'b000;
      s2_q    <= 3'b000;
      cand_q  <= 3'b000;
      cnt_q   <= 8'd0;
      state_q <= 3'b000;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/hall_speed_sensor.sv
// Hall front end: debounced state, direction, position, period, stall.
// Define HALL_IRQ_EN to build the interrupt logic.
module hall_speed_sensor
  import hall_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 4,
  parameter logic [31:0] TIMEOUT_RST = 32'd0
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset_n,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  input  logic [31:0] avs_ctrl_writedata,
  input  logic [3:0]  avs_ctrl_byteenable,
  output logic [31:0] avs_ctrl_readdata,
  output logic        avs_ctrl_waitrequest,
  input  logic        Ha,
  input  logic        Hb,
  input  logic        Hc,
  output logic [2:0]  hall_o,
  output logic        hall_valid,
  output logic        dir_o,
  output logic        irq
);

  logic clk, rst_n;
  assign clk   = csi_MCLK_clk;
  assign rst_n = rsi_MRST_reset_n;

  logic [2:0]  f_state;
  logic        f_chg;

  hall_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   ({Ha, Hb, Hc}),
    .state_o (f_state),
    .chg_o   (f_chg)
  );

  logic [2:0]  hall_q, hall_d;
  logic        valid_q, valid_d;
  logic        dir_q, dir_d;
  logic        err_q, err_d;
  logic        stall_q, stall_d;
  logic [31:0] pos_q, pos_d;
  logic [31:0] per_q, per_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        trans, err_set;
  logic        wr_pos, wr_tmo, wr_ctrl;

  assign wr_pos  = avs_ctrl_write && avs_ctrl_address == ADDR_POS;
  assign wr_tmo  = avs_ctrl_write && avs_ctrl_address == ADDR_TMO;
  assign wr_ctrl = avs_ctrl_write && avs_ctrl_address == ADDR_CTRL;

  always_comb begin
    hall_d  = hall_q;
    valid_d = valid_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    per_d   = per_q;
    stall_d = stall_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    trans   = 1'b0;
    err_set = 1'b0;
    cnt_d   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    if (tmo_q != 32'd0 && cnt_q == tmo_q) begin
      stall_d = 1'b1;
      per_d   = 32'd0;
    end

    if (f_chg) begin
      if (!hall_legal(f_state)) begin
        err_set = 1'b1;
      end else if (!valid_q) begin
        hall_d  = f_state;
        valid_d = 1'b1;
      end else if (f_state == hall_next(hall_q)) begin
        hall_d = f_state;
        dir_d  = 1'b1;
        pos_d  = pos_q + 32'd1;
        trans  = 1'b1;
      end else if (f_state == hall_prev(hall_q)) begin
        hall_d = f_state;
        dir_d  = 1'b0;
        pos_d  = pos_q - 32'd1;
        trans  = 1'b1;
      end else if (f_state != hall_q) begin
        hall_d  = f_state;
        err_set = 1'b1;
      end
    end

    if (trans) begin
      per_d   = cnt_q;
      cnt_d   = 32'd1;
      stall_d = 1'b0;
    end

    if (wr_ctrl && avs_ctrl_writedata[1]) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
    if (wr_pos)
      pos_d = be_merge(pos_q, avs_ctrl_writedata, avs_ctrl_byteenable);
    if (wr_tmo)
      tmo_d = be_merge(tmo_q, avs_ctrl_writedata, avs_ctrl_byteenable);
  end

`ifdef HALL_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic pend_q, pend_d;

  always_comb begin
    irq_en_d = irq_en_q;
    pend_d   = pend_q;
    if (wr_ctrl) begin
      irq_en_d = avs_ctrl_writedata[0];
      if (avs_ctrl_writedata[2]) pend_d = 1'b0;
    end
    if ((err_d & ~err_q) | (stall_d & ~stall_q)) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
    end
  end

  assign irq = pend_q & irq_en_q;
`else
  logic irq_en_q, pend_q;
  assign irq_en_q = 1'b0;
  assign pend_q   = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (avs_ctrl_read) begin
      case (avs_ctrl_address)
        ADDR_ID:     rdata_d = HALL_ID;
        ADDR_STATUS: rdata_d = {24'b0, pend_q, stall_q, err_q,
                                dir_q, valid_q, hall_q};
        ADDR_PERIOD: rdata_d = per_q;
        ADDR_POS:    rdata_d = pos_q;
        ADDR_TMO:    rdata_d = tmo_q;
        ADDR_CTRL:   rdata_d = {31'b0, irq_en_q};
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_q  <= 3'b000;
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      pos_q   <= 32'd0;
      per_q   <= 32'd0;
      cnt_q   <= 32'd0;
      tmo_q   <= TIMEOUT_RST;
      rdata_q <= 32'd0;
    end else begin
      hall_q  <= hall_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      pos_q   <= pos_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
    end
  end

  assign hall_o               = hall_q;
  assign hall_valid           = valid_q;
  assign dir_o                = dir_q;
  assign avs_ctrl_readdata    = rdata_q;
  assign avs_ctrl_waitrequest = 1'b0;

endmodule

// File: tb/tb_hall_speed_sensor.sv
// Directed bench for hall_speed_sensor: register reads go through a
// scoreboard queue; pin-level outputs are compared directly.
module tb_hall_speed_sensor;

`ifdef HALL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  localparam logic [31:0] PEND = IRQ_ON ? 32'h80 : 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  be = 4'hF;
  logic [31:0] readdata;
  logic        waitreq;
  logic        Ha = 1'b1, Hb = 1'b0, Hc = 1'b0;
  logic [2:0]  hall_o;
  logic        hall_valid, dir_o, irq;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  logic [2:0] fwd [6];
  logic [2:0] rev [7];

  always #5 clk = ~clk;

  hall_speed_sensor #(.FILT_LEN(4), .TIMEOUT_RST(32'd0)) dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset_n     (rst_n),
    .avs_ctrl_address     (address),
    .avs_ctrl_write       (write),
    .avs_ctrl_read        (read),
    .avs_ctrl_writedata   (wdata),
    .avs_ctrl_byteenable  (be),
    .avs_ctrl_readdata    (readdata),
    .avs_ctrl_waitrequest (waitreq),
    .Ha                   (Ha),
    .Hb                   (Hb),
    .Hc                   (Hc),
    .hall_o               (hall_o),
    .hall_valid           (hall_valid),
    .dir_o                (dir_o),
    .irq                  (irq)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_hall(input logic [2:0] h);
    {Ha, Hb, Hc} = h;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    address = a; wdata = d; be = b; write = 1'b1;
    tick(1);
    write = 1'b0; be = 4'hF;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp,
                    input string tag);
    exp_t e;
    sb.push_back('{tag: tag, exp: exp});
    address = a; read = 1'b1;
    tick(1);
    read = 1'b0;
    e = sb.pop_front();
    chk(e.tag, readdata, e.exp);
  endtask

  initial begin
    fwd = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    rev = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    tick(3);
    chk("rst_hall", 32'(hall_o), 32'h0);
    chk("rst_valid", 32'(hall_valid), 32'h0);
    chk("rst_dir", 32'(dir_o), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", readdata, 32'h0);
    chk("waitreq", 32'(waitreq), 32'h0);
    rst_n = 1'b1;
    tick(10);
    chk("seed_hall", 32'(hall_o), 32'h4);
    chk("seed_valid", 32'(hall_valid), 32'h1);
    rd(3'd0, 32'hEA68_0004, "id");
    rd(3'd1, 32'h0C, "seed_status");
    rd(3'd3, 32'h0, "seed_pos");
    rd(3'd4, 32'h0, "rst_tmo");

    for (int i = 1; i <= 6; i++) begin
      set_hall(fwd[i % 6]);
      tick(5);
      chk("lag_hold", 32'(hall_o), 32'(fwd[i-1]));
      tick(1);
      chk("lag_upd", 32'(hall_o), 32'(fwd[i % 6]));
      tick(994);
    end
    rd(3'd3, 32'd6, "rev_pos");
    chk("rev_dir", 32'(dir_o), 32'h1);
    rd(3'd2, 32'd1000, "period");

    set_hall(3'b000);
    tick(3);
    set_hall(3'b100);
    tick(10);
    chk("glitch_hall", 32'(hall_o), 32'h4);
    rd(3'd3, 32'd6, "glitch_pos");
    rd(3'd1, 32'h1C, "glitch_status");

    wr(3'd3, 32'd5, 4'hF);
    for (int i = 0; i < 7; i++) begin
      set_hall(rev[i]);
      tick(20);
    end
    rd(3'd3, 32'hFFFF_FFFE, "revseq_pos");
    chk("revseq_dir", 32'(dir_o), 32'h0);
    chk("revseq_hall", 32'(hall_o), 32'h5);

    wr(3'd3, 32'h1234_5678, 4'b0001);
    rd(3'd3, 32'hFFFF_FF78, "pos_be");
    set_hall(3'b100);
    tick(20);
    rd(3'd3, 32'hFFFF_FF79, "fwd_pos");

    wr(3'd5, 32'h1, 4'hF);
    rd(3'd5, 32'(IRQ_ON), "ctrl_en");
    set_hall(3'b111);
    tick(20);
    chk("illegal_hall", 32'(hall_o), 32'h4);
    rd(3'd1, 32'h3C | PEND, "illegal_status");
    chk("illegal_irq", 32'(irq), 32'(IRQ_ON));
    rd(3'd3, 32'hFFFF_FF79, "illegal_pos");
    set_hall(3'b100);
    tick(20);
    wr(3'd5, 32'h6, 4'hF);
    chk("clr_irq", 32'(irq), 32'h0);
    rd(3'd1, 32'h1C, "clr_status");

    set_hall(3'b010);
    tick(20);
    chk("skip_hall", 32'(hall_o), 32'h2);
    chk("skip_dir", 32'(dir_o), 32'h1);
    rd(3'd1, 32'h3A | PEND, "skip_status");
    rd(3'd3, 32'hFFFF_FF79, "skip_pos");
    wr(3'd5, 32'h1, 4'hF);
    chk("skip_irq", 32'(irq), 32'(IRQ_ON));
    wr(3'd5, 32'h6, 4'hF);
    chk("skip_clr_irq", 32'(irq), 32'h0);
    rd(3'd1, 32'h1A, "skip_clr_status");

    wr(3'd4, 32'd500, 4'hF);
    rd(3'd4, 32'd500, "tmo_rd");
    set_hall(3'b011);
    tick(6);
    tick(499);
    rd(3'd1, 32'h1B, "stall_pre");
    rd(3'd1, 32'h5B | PEND, "stall_set");
    rd(3'd2, 32'h0, "stall_period");
    set_hall(3'b001);
    tick(20);
    rd(3'd1, 32'h19 | PEND, "stall_clr");

    set_hall(3'b101);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hall", 32'(hall_o), 32'h0);
    chk("mid_rst_valid", 32'(hall_valid), 32'h0);
    chk("mid_rst_dir", 32'(dir_o), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_rdata", readdata, 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(10);
    chk("reseed_hall", 32'(hall_o), 32'h5);
    chk("reseed_valid", 32'(hall_valid), 32'h1);
    rd(3'd3, 32'h0, "reseed_pos");
    rd(3'd1, 32'h0D, "reseed_status");
    rd(3'd4, 32'h0, "reseed_tmo");
    rd(3'd2, 32'h0, "reseed_period");
    rd(3'd6, 32'h0, "unmapped");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
